// File: rtl/mux_arb_nx1.sv
// N-to-1 datapath multiplexer with one registered output stage and valid/ready on every channel.
// The source channel is either steered by sel (ARB=0) or picked round-robin among valid channels (ARB=1).
module mux_arb_nx1 #(
  parameter int W   = 32,
  parameter int N   = 4,
  parameter int ARB = 0,
  localparam int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  e,
  input  logic [N-1:0]    e_valid,
  output logic [N-1:0]    e_ready,
  input  logic [SW-1:0]   sel,
  output logic [W-1:0]    salMux,
  output logic            sal_valid,
  input  logic            sal_ready,
  output logic [SW-1:0]   sal_ch
);

  localparam int            NP    = 1 << SW;
  localparam logic [SW:0]   N_EXT = (SW+1)'(N);
  localparam logic [SW-1:0] LAST  = SW'(N-1);

  logic [W-1:0]  data_q, data_d;
  logic [SW-1:0] ch_q, ch_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic          valid_q, valid_d;

  logic [SW-1:0] cand;
  logic          hit;
  logic          sel_ok;
  logic          load_en;
  logic [W-1:0]  data_sel;
  logic [SW:0]   sum;
  logic [NP-1:0] valid_pad;

  // Padding e_valid to 2**SW bits keeps every index in range when N is not a power of two.
  assign valid_pad = NP'(e_valid);
  assign sel_ok    = ({1'b0, sel} < N_EXT);

  // Reset also blocks acceptance, so no producer sees a grant while the stage is being cleared.
  assign load_en = rst_n && (!valid_q || sal_ready);

  // NOTE: every variable written in an always_comb gets a default first; a missing path would infer a latch.
  always_comb begin
    cand = '0;
    hit  = 1'b0;
    sum  = '0;
    if (ARB == 0) begin
      cand = sel;
      hit  = sel_ok && valid_pad[sel];
    end else begin
      // Walk from the farthest slot back to ptr so the nearest valid channel is the last one written.
      for (int k = N-1; k >= 0; k--) begin
        sum = {1'b0, ptr_q} + (SW+1)'(k);
        if (sum >= N_EXT) sum = sum - N_EXT;
        if (valid_pad[sum[SW-1:0]]) begin
          cand = sum[SW-1:0];
          hit  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    e_ready = '0;
    if (load_en) begin
      if (ARB == 0) begin
        if (sel_ok) e_ready = N'(1) << sel;
      end else if (hit) begin
        e_ready = N'(1) << cand;
      end
    end
  end

  always_comb begin
    data_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (cand == SW'(i)) data_sel = e[i*W +: W];
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    if (load_en) begin
      valid_d = hit;
      if (hit) begin
        data_d = data_sel;
        ch_d   = cand;
        if (ARB != 0) ptr_d = (cand == LAST) ? '0 : cand + SW'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      ch_q    <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
    end
  end

  assign salMux    = data_q;
  assign sal_valid = valid_q;
  assign sal_ch    = ch_q;

endmodule

// File: doc/mux_arb_nx1.md
# mux_arb_nx1

Parametrised N-to-1 datapath multiplexer with one registered output stage and a valid/ready handshake on every channel. Used in the rv32i datapath wherever several producers (ALU, memory, immediate, PC+4) share one destination bus. Selection is either steered (`sel` input) or round-robin arbitrated among valid channels. Latency is one cycle and throughput is one word per cycle.

## Interface
- `W`, 32, data width per channel
- `N`, 4, channel count, 2..16; need not be a power of two
- `ARB`, 0, 0 = steered by `sel`, 1 = round-robin among valid channels (`sel` ignored)
- `SW`, local, `$clog2(N)`, width of `sel` and `sal_ch`

Ports:
- `clk`  in  1  clock, all state updates on the rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `e`  in  N*W  flattened channel data; channel i at `e[i*W +: W]`
- `e_valid`  in  N  per-channel data valid
- `e_ready`  out  N  per-channel accept; a transfer happens when `e_valid[i] && e_ready[i]`
- `sel`  in  SW  channel select, used only when ARB=0
- `salMux`  out  W  registered output word
- `sal_valid`  out  1  `salMux` holds a valid word
- `sal_ready`  in  1  downstream accepts `salMux`
- `sal_ch`  out  SW  index of the channel that produced `salMux`

## Operation
- `load_en = !sal_valid || sal_ready`. The output register may load only when `load_en` is true.
- Candidate channel c:
  - ARB=0: c = `sel`.
  - ARB=1: the first i with `e_valid[i]`, searching ptr, ptr+1, … modulo N.
- `ptr` is an internal SW-bit round-robin pointer; reset value is 0.
- `hit` is true when a candidate exists and `e_valid[c]` is set.
  - ARB=0 with `sel >= N`: `hit=0`.
  - ARB=1 with no valid channel: `hit=0`.
- `e_ready`:
  - ARB=0: `e_ready[c] = load_en` when `sel < N` (independent of `e_valid`); all other bits are 0.
  - ARB=1: `e_ready[c] = load_en && hit`; all other bits are 0.
  - At most one `e_ready` bit is high in any cycle.
- On a clock edge with `load_en`:
  - If `hit`: `salMux <= e[c]`, `sal_ch <= c`, `sal_valid <= 1`. When ARB=1, also `ptr <= (c+1) mod N`.
  - Else: `sal_valid <= 0`. `salMux` and `sal_ch` hold their old values.
- Stall (`sal_valid && !sal_ready`):
  - `salMux`, `sal_ch`, `sal_valid` and `ptr` hold.
  - All `e_ready` bits are 0.
  - Changes on `sel`, `e` or `e_valid` have no effect.
- Reset (`rst_n=0`, asynchronous, any time including mid-stall):
  - `salMux=0`, `sal_valid=0`, `sal_ch=0`, `ptr=0`, all `e_ready=0`.
  - Any in-flight word is discarded.
  - After release, the first load can occur on the first rising edge with `rst_n=1`.
- Width rules:
  - Data passes through unmodified; there is no arithmetic.
  - `ptr` wraps from N-1 to 0. It never takes a value ≥ N, including when N is not a power of two.

## Timing
- Latency: input sampled on edge k appears on `salMux` and `sal_valid` after edge k.
- Throughput is 1 word/cycle while `sal_ready=1`; no bubble is inserted between back-to-back words.
- `e_ready` is combinational from `sal_valid`, `sal_ready`, `sel`, `e_valid` and `ptr`. There is no combinational path from `e` to any output.
- `sal_valid` may only fall on an edge where `load_en && !hit`.
- Simultaneous stall release and new data: a word is accepted on the same edge that the held word is consumed.

## Test plan
- Reset: assert `rst_n=0` between edges -> immediately `sal_valid=0`, `salMux=0`, `sal_ch=0`, `e_ready=0`; after release with idle inputs, outputs stay at 0.
- ARB=0, N=4, W=32, `e`={1,2,3,4}, all valid, `sal_ready=1`, `sel`=0,1,2,3 on consecutive cycles -> `salMux`=1,2,3,4 and `sal_ch`=0,1,2,3, each one cycle after the matching `sel`; `sal_valid` stays 1.
- Stall: hold `sal_ready=0` while `salMux=3`, then change `sel` to 0 -> `salMux=3` and `sal_ch=2` hold, `e_ready=0000`; raise `sal_ready` -> next edge `salMux=1`.
- ARB=1, all valid, `sal_ready=1` -> `sal_ch`=0,1,2,3,0,1 on consecutive cycles. With only ch1 and ch3 valid -> 1,3,1,3. With `e_valid=0` -> `sal_valid` falls after one edge.
- ARB=0, N=3, `sel=3` -> `e_ready=000`, `sal_valid` falls to 0 on the next edge with `sal_ready=1`, `salMux` holds its last value.
- Asynchronous reset mid-stall (`sal_valid=1`, `sal_ready=0`, ARB=1, ptr=2) -> immediate clear. After release with all valid, the first grant is ch0.
